frame_tx_arbiter: RTL and testbench

Shares a single narrow serial transmit link between several word-wide requesters. A round-robin arbiter grants one requester and captures its word. The block then sequences the word out in CHUNK_W-bit chunks, MSB chunk first, over a valid/ready link. It sits between the packet-assembly clients of the networking layer and the physical-layer chunk transmitter.

---
 rtl/frame_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_frame_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_arbiter.sv
// frame_tx_arbiter: round-robin arbiter that captures one requester word
// and serialises it MSB chunk first over a valid/ready chunk link.
// Optional feature macro: FRAME_TX_CHECKSUM_EN appends an XOR checksum chunk.
module frame_tx_arbiter #(
  parameter int WORD_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [CHUNK_W-1:0]        out_chunk,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      busy
);

  localparam int NCHUNK = WORD_W / CHUNK_W;
  localparam int IDW    = $clog2(NUM_REQ);
  localparam int CW     = $clog2(NCHUNK + 1);

`ifdef FRAME_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t              state, state_n;
  logic [WORD_W-1:0]   shift_reg;
  logic [CW-1:0]       chunk_cnt;
  logic [IDW-1:0]      last_grant;
  logic [IDW-1:0]      winner;
  logic                found;
  logic                accept;
  logic                last_chunk;
  logic [CHUNK_W-1:0]  head;
  logic [WORD_W-1:0]   req_word [NUM_REQ];
`ifdef FRAME_TX_CHECKSUM_EN
  logic [CHUNK_W-1:0]  csum;
`endif

  // Unpack the flat request bus into per-requester words.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*WORD_W +: WORD_W];
  end

  assign head       = shift_reg[WORD_W-1 -: CHUNK_W];
  assign last_chunk = (chunk_cnt == CW'(NCHUNK - 1));
  assign accept     = (state == IDLE) && found;
  assign busy       = (state != IDLE);

  // Round-robin search upward from the requester after the last grant.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  // Next-state and link outputs, decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_n   = state;
    req_ready = '0;
    out_valid = 1'b0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    out_chunk = head;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          state_n           = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_sof   = (chunk_cnt == '0);
`ifdef FRAME_TX_CHECKSUM_EN
        if (out_ready && last_chunk) state_n = CSUM;
`else
        out_eof   = last_chunk;
        if (out_ready && last_chunk) state_n = IDLE;
`endif
      end
`ifdef FRAME_TX_CHECKSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        out_eof   = 1'b1;
        out_chunk = csum;
        if (out_ready) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // State, word capture, shifting and chunk counting.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: async active-low reset; all sequential state uses non-blocking assignments.
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      chunk_cnt  <= '0;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
`ifdef FRAME_TX_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        shift_reg  <= req_word[winner];
        grant_id   <= winner;
        last_grant <= winner;
        chunk_cnt  <= '0;
`ifdef FRAME_TX_CHECKSUM_EN
        csum       <= '0;
`endif
      end else if (state == SEND && out_ready) begin
        shift_reg <= shift_reg << CHUNK_W;
        chunk_cnt <= chunk_cnt + 1'b1;
`ifdef FRAME_TX_CHECKSUM_EN
        csum      <= csum ^ head;
`endif
      end
    end
  end

endmodule

// File: tb/tb_frame_tx_arbiter.sv
// Scoreboard bench for frame_tx_arbiter: tasks push expected chunks, a
// negedge monitor pops and compares on every link handshake.
module tb_frame_tx_arbiter;

  localparam int WORD_W  = 32;
  localparam int CHUNK_W = 8;
  localparam int NUM_REQ = 2;
  localparam int NCHUNK  = WORD_W / CHUNK_W;
`ifdef FRAME_TX_CHECKSUM_EN
  localparam int FRAME_CYC = NCHUNK + 1;
`else
  localparam int FRAME_CYC = NCHUNK;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*WORD_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [CHUNK_W-1:0]        out_chunk;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic                      out_sof;
  logic                      out_eof;
  logic [0:0]                grant_id;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CHUNK_W-1:0] chunk;
    logic               sof;
    logic               eof;
    logic [0:0]         id;
  } exp_t;

  exp_t sb[$];

  frame_tx_arbiter #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_chunk(out_chunk), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Compare every accepted chunk against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_chunk got %h sof=%b eof=%b", out_chunk, out_sof, out_eof);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_chunk, out_sof, out_eof, grant_id} !== {e.chunk, e.sof, e.eof, e.id}) begin
          errors++;
          $display("FAIL chunk got %h/sof%b/eof%b/id%0d expected %h/sof%b/eof%b/id%0d",
                   out_chunk, out_sof, out_eof, grant_id, e.chunk, e.sof, e.eof, e.id);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [WORD_W-1:0] w, input logic [0:0] id);
    logic [CHUNK_W-1:0] x;
    exp_t e;
    x = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      e.chunk = w[WORD_W-1-k*CHUNK_W -: CHUNK_W];
      e.sof   = (k == 0);
`ifdef FRAME_TX_CHECKSUM_EN
      e.eof   = 1'b0;
`else
      e.eof   = (k == NCHUNK - 1);
`endif
      e.id    = id;
      x       = x ^ e.chunk;
      sb.push_back(e);
    end
`ifdef FRAME_TX_CHECKSUM_EN
    e.chunk = x; e.sof = 1'b0; e.eof = 1'b1; e.id = id;
    sb.push_back(e);
`endif
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    cmp("reset_outputs", {out_valid, out_sof, out_eof, out_chunk, req_ready, grant_id, busy}, '0);
    do_reset();
    cmp("idle_outputs", {out_valid, req_ready, busy}, '0);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    req_data[0 +: WORD_W] = 32'hDEADBEEF;
    req_valid = 2'b01;
    #1;
    cmp("single_req_ready", req_ready, 2'b01);
    push_frame(32'hDEADBEEF, 1'b0);
    tick();
    req_valid = '0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      cmp("single_valid", {out_valid, busy, req_ready}, {2'b11, 2'b00});
      tick();
    end
    cmp("single_done", {out_valid, busy}, 2'b00);
    cmp("single_sb_empty", sb.size(), 0);
  endtask

  task automatic test_contention();
    logic [0:0] exp_id;
    do_reset();
    out_ready = 1'b1;
    req_data = {32'h55667788, 32'h11223344};
    req_valid = 2'b11;
    for (int f = 0; f < 3; f++) begin
      exp_id = f[0];
      #1;
      cmp("cont_idle", {out_valid, busy}, 2'b00);
      cmp("cont_grant", req_ready, exp_id ? 2'b10 : 2'b01);
      push_frame(exp_id ? 32'h55667788 : 32'h11223344, exp_id);
      tick();
      for (int k = 0; k < FRAME_CYC; k++) begin
        cmp("cont_send", {out_valid, req_ready}, {1'b1, 2'b00});
        tick();
      end
    end
    req_valid = '0;
    tick();
    cmp("cont_sb_empty", sb.size(), 0);
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1;
    req_data[0 +: WORD_W] = 32'hCAFEF00D;
    req_valid = 2'b01;
    push_frame(32'hCAFEF00D, 1'b0);
    tick();
    req_valid = '0;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmp("bp_hold", {out_valid, out_sof, out_eof, out_chunk}, {3'b100, 8'hFE});
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < FRAME_CYC - 1; k++) tick();
    cmp("bp_done", {out_valid, busy}, 2'b00);
    cmp("bp_sb_empty", sb.size(), 0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    out_ready = 1'b1;
    req_data[0 +: WORD_W] = 32'h12345678;
    req_valid = 2'b01;
    push_frame(32'h12345678, 1'b0);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    cmp("midrst_outputs", {out_valid, out_sof, out_eof, out_chunk, req_ready, grant_id, busy}, '0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    req_data = {32'hA5A5_5A5A, 32'h0F0F_F0F0};
    req_valid = 2'b11;
    #1;
    cmp("midrst_prio0", req_ready, 2'b01);
    req_valid = 2'b10;
    #1;
    cmp("midrst_prio1", req_ready, 2'b10);
    push_frame(32'hA5A5_5A5A, 1'b1);
    tick();
    req_valid = '0;
    for (int k = 0; k < FRAME_CYC; k++) tick();
    cmp("midrst_sb_empty", sb.size(), 0);
  endtask

`ifdef FRAME_TX_CHECKSUM_EN
  task automatic test_checksum();
    int sof_cycles[$];
    do_reset();
    out_ready = 1'b1;
    req_data[0 +: WORD_W] = 32'h01020408;
    req_valid = 2'b01;
    push_frame(32'h01020408, 1'b0);
    push_frame(32'h01020408, 1'b1);
    for (int c = 0; c < 14; c++) begin
      if (out_valid && out_sof) sof_cycles.push_back(c);
      req_valid = (req_ready != 0 || busy) ? req_valid : req_valid;
      if (req_ready == 2'b01) req_data[WORD_W +: WORD_W] = 32'h01020408;
      if (req_ready == 2'b01) req_valid = 2'b10;
      tick();
      if (busy) req_valid = (c < 4) ? 2'b10 : 2'b00;
    end
    req_valid = '0;
    cmp("csum_frames", sof_cycles.size(), 2);
    if (sof_cycles.size() == 2) cmp("csum_period", sof_cycles[1] - sof_cycles[0], 6);
    cmp("csum_sb_empty", sb.size(), 0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid_frame();
`ifdef FRAME_TX_CHECKSUM_EN
    test_checksum();
`endif
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
